// File: rtl/mul_share_ctrl.sv
// Controller that time-shares one repeated-addition multiplier datapath between
// two requesters with round-robin arbitration.
module mul_share_ctrl #(
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             eqz,
  input  logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] bus_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_p,
  output logic             clr_p,
  output logic             dec_b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  logic   win;
  logic   last;
  logic   calc;
  logic   pick;

  // Round-robin choice: a lone requester wins, otherwise the one not served last.
  assign pick = (req0 && req1) ? ~last : req1;

  // Accumulate/decrement must react to eqz in the same cycle it is observed.
  assign ld_p  = calc & ~eqz;
  assign dec_b = calc & ~eqz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      win     <= 1'b0;
      last    <= 1'b1;
      calc    <= 1'b0;
      bus_out <= '0;
      ld_a    <= 1'b0;
      ld_b    <= 1'b0;
      clr_p   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
    end else begin
      bus_out <= '0;
      ld_a    <= 1'b0;
      ld_b    <= 1'b0;
      clr_p   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= LOADA;
            win     <= pick;
            busy    <= 1'b1;
            bus_out <= pick ? a1 : a0;
            ld_a    <= 1'b1;
            clr_p   <= 1'b1;
            gnt0    <= ~pick;
            gnt1    <= pick;
          end
        end
        LOADA: begin
          state   <= LOADB;
          bus_out <= win ? b1 : b0;
          ld_b    <= 1'b1;
        end
        LOADB: begin
          state <= CALC;
          calc  <= 1'b1;
        end
        CALC: begin
          if (eqz) begin
            state  <= DONE;
            calc   <= 1'b0;
            result <= prod;
            done0  <= ~win;
            done1  <= win;
          end
        end
        DONE: begin
          state <= IDLE;
          last  <= win;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          calc  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
